// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter sharing one single-port, fixed-latency
//                memory between PORTS level-req / one-cycle-ack requesters.
//                One transaction in flight; all outputs registered.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int PORTS   = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PORTS-1:0]    req,
    input  logic [PORTS-1:0]    rw,
    input  logic [PORTS*AW-1:0] addr,
    input  logic [PORTS*DW-1:0] wdata,
    output logic [PORTS-1:0]    ack,
    output logic [DW-1:0]       rdata,
    output logic                busy,
    output logic                mem_strobe,
    output logic                mem_rw,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
);

    localparam int PW = (PORTS > 1)   ? $clog2(PORTS)   : 1;
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_grant;
    logic [PW-1:0]   r_last;
    logic            r_rw;
    logic [CW-1:0]   r_cnt;

    logic            w_found;
    logic [PW-1:0]   w_pick;
    logic [PW:0]     w_idx;

    // Round-robin pick: first set req scanning last+1 .. last+PORTS (mod PORTS)
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= PORTS; i++) begin
            w_idx = {1'b0, r_last} + (PW+1)'(i);
            if (w_idx >= (PW+1)'(PORTS)) begin
                w_idx = w_idx - (PW+1)'(PORTS);
            end
            if (!w_found && req[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[PW-1:0];
            end
        end
    end

    // Next-state logic: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered datapath and outputs; everything is computed one edge ahead
    // so the outputs line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant    <= '0;
            r_last     <= PW'(PORTS-1);
            r_rw       <= 1'b0;
            r_cnt      <= '0;
            ack        <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
            mem_strobe <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            busy <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    ack <= '0;
                    if (w_found) begin
                        r_grant    <= w_pick;
                        r_rw       <= rw[w_pick];
                        mem_addr   <= addr[w_pick*AW +: AW];
                        mem_wdata  <= wdata[w_pick*DW +: DW];
                        mem_strobe <= 1'b1;
                        mem_rw     <= rw[w_pick];
                    end
                end
                S_ISSUE: begin
                    mem_strobe <= 1'b0;
                    mem_rw     <= 1'b0;
                    r_cnt      <= CW'(MEM_LAT-1);
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        // Read data is valid in the last WAIT cycle only
                        if (!r_rw) begin
                            rdata <= mem_rdata;
                        end
                        ack <= {{(PORTS-1){1'b0}}, 1'b1} << r_grant;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    ack    <= '0;
                    r_last <= r_grant;
                end
                default: begin
                    ack        <= '0;
                    mem_strobe <= 1'b0;
                    mem_rw     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
